// File: rtl/uart_tx_arb.sv
// Round-robin arbiter: four byte requesters share one UART transmitter.
// Latency: req_ready is given in the IDLE cycle, tx_start follows one cycle later, and done arrives once tx_busy falls.
// Backpressure: no grant while tx_busy is high or a frame is in flight. Requesters hold valid and data until they see req_ready.
//
// Ports
//   clk        core clock; all state changes on its rising edge
//   rst        asynchronous active-low reset
//   req_valid  per-requester "byte pending" flags
//   req_data   requester i byte at [i*BIT_MAX +: BIT_MAX]
//   req_ready  one-hot, one-cycle accept pulse to the winner
//   tx_data    latched byte presented to the transmitter
//   tx_start   one-cycle launch pulse
//   tx_busy    transmitter is shifting a frame
//   grant_id   index of the current or most recent winner
//   busy       FSM is not IDLE
//   done       one-cycle pulse when the granted frame completes
//   err        one-cycle pulse when tx_busy never rose after tx_start
module uart_tx_arb #(
    parameter int BIT_MAX  = 8,
    parameter int WAIT_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req_valid,
    input  logic [4*BIT_MAX-1:0] req_data,
    output logic [3:0]           req_ready,
    output logic [BIT_MAX-1:0]   tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // The counter only has to hold WAIT_MAX-1. It never counts past that value.
    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [1:0]         last_grant_q;
    logic [1:0]         grant_id_q;
    logic [CW-1:0]      wait_cnt_q;
    logic [BIT_MAX-1:0] tx_data_q;
    logic               tx_start_q;
    logic               busy_q;

    logic [1:0]         winner;
    logic [1:0]         cand;
    logic               grant_vld;

    // Round-robin search. Offsets run from 4 down to 1 and are taken modulo 4,
    // so the candidate closest after last_grant is assigned last and wins.
    // Offset 4 is last_grant itself, so a lone requester can be served again.
    always_comb begin
        winner = last_grant_q + 2'd1;
        cand   = last_grant_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_grant_q + 2'(k);
            if (req_valid[cand]) begin
                winner = cand;
            end
        end
    end

    // Accept is decided within the IDLE cycle, so req_ready pulses in the same
    // cycle in which the byte is latched. The rst term keeps req_ready low
    // while reset is held, even though IDLE is the reset state.
    assign grant_vld = (state_q == IDLE) && rst && !tx_busy && (|req_valid);
    assign req_ready = grant_vld ? (4'b0001 << winner) : 4'b0000;

    // Each completion pulse is tied to a single state, so req_ready, tx_start,
    // done and err can never be asserted together.
    assign done = (state_q == WAIT_DONE) && !tx_busy;
    assign err  = (state_q == WAIT_BUSY) && !tx_busy && (wait_cnt_q == CNT_LAST);

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;   // requester 0 gets first priority after reset
            grant_id_q   <= 2'd3;
            wait_cnt_q   <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        tx_data_q    <= req_data[winner*BIT_MAX +: BIT_MAX];
                        grant_id_q   <= winner;
                        last_grant_q <= winner;
                        tx_start_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_start_q <= 1'b0;
                    wait_cnt_q <= '0;
                    state_q    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        // The transmitter never started. The byte is dropped, not retried.
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb.
// The transmitter model raises tx_busy 2 cycles after tx_start and holds it for 20 cycles.
// All checks go through chk(). Outputs are sampled on the falling edge.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        busy;
    logic        done;
    logic        err;

    uart_tx_arb #(.BIT_MAX(8), .WAIT_MAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sampled outputs and event log
    logic [3:0] s_ready;
    logic       s_start, s_done, s_err, s_busy;
    logic [7:0] s_txd;
    logic [1:0] s_gid;
    int cyc = 0, ready_cnt = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
    int done_cyc = 0, err_cyc = 0, start_cyc = 0;
    int excl_bad = 0, onehot_bad = 0;
    bit have_done = 0;
    int grant_q[$];
    int txd_q[$];
    int gap_q[$];

    // Transmitter model: mode 0 = normal, 1 = never busy, 2 = driven by hand
    int xmode = 0;
    int dly = 0;
    int rem = 0;

    task automatic tick();
        int g;
        @(negedge clk);
        s_ready = req_ready;
        s_start = tx_start;
        s_done  = done;
        s_err   = err;
        s_busy  = busy;
        s_txd   = tx_data;
        s_gid   = grant_id;
        if (s_ready != 4'b0000) begin
            ready_cnt++;
            if (!$onehot(s_ready)) onehot_bad++;
            g = 0;
            for (int i = 0; i < 4; i++) if (s_ready[i]) g = i;
            grant_q.push_back(g);
            if (have_done) gap_q.push_back(cyc - done_cyc);
        end
        if (s_start) begin
            start_cnt++;
            start_cyc = cyc;
            txd_q.push_back(int'(s_txd));
            if (xmode == 0) dly = 2;
        end
        if (s_done) begin
            done_cnt++;
            done_cyc = cyc;
            have_done = 1;
        end
        if (s_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if ((int'(s_ready != 4'b0000) + int'(s_start) + int'(s_done) + int'(s_err)) > 1) excl_bad++;
        cyc++;
        @(posedge clk);
        #1;
        if (xmode == 0) begin
            if (tx_busy) begin
                rem--;
                if (rem == 0) tx_busy = 1'b0;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    tx_busy = 1'b1;
                    rem = 20;
                end
            end
        end else if (xmode == 1) begin
            tx_busy = 1'b0;
        end
    endtask

    // Tick until a done or err pulse is seen, or until the budget runs out.
    task automatic wait_end(input int budget, input string tag);
        int d0;
        int n;
        d0 = done_cnt + err_cnt;
        n = 0;
        while ((done_cnt + err_cnt) == d0 && n < budget) begin
            tick();
            n++;
        end
        if ((done_cnt + err_cnt) == d0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        int en;
        rst = 1'b1;
        req_valid = 4'b0000;
        req_data = 32'h0;
        tx_busy = 1'b0;

        // Reset values
        #1 rst = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_start", 32'(tx_start), 32'h0);
        chk("rst_txd",   32'(tx_data), 32'h0);
        chk("rst_gid",   32'(grant_id), 32'h3);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_err",   32'(err), 32'h0);
        req_valid = 4'hF;
        #1 chk("rst_ready_gated", 32'(req_ready), 32'h0);
        req_valid = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single request
        req_data = 32'h0000_00A5;
        req_valid = 4'b0001;
        tick();
        chk("t1_ready", 32'(s_ready), 32'h1);
        req_valid = 4'b0000;
        req_data = 32'h0000_00FF;
        tick();
        chk("t1_start", 32'(s_start), 32'h1);
        chk("t1_txd",   32'(s_txd), 32'hA5);
        chk("t1_gid",   32'(s_gid), 32'h0);
        chk("t1_busy",  32'(s_busy), 32'h1);
        wait_end(60, "t1");
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_lat", done_cyc - start_cyc, 22);
        chk("t1_err_cnt", err_cnt, 0);
        tick();
        chk("t1_idle", 32'(s_busy), 32'h0);
        chk("t1_hold_txd", 32'(s_txd), 32'hA5);
        chk("t1_ready_cnt", ready_cnt, 1);

        // Reset while idle so that the fairness order starts at requester 0
        #1 rst = 1'b0;
        #1 chk("rp_gid", 32'(grant_id), 32'h3);
        rst = 1'b1;

        // Fairness: all four requesters held valid for 8 frames
        grant_q.delete();
        txd_q.delete();
        gap_q.delete();
        have_done = 0;
        req_data = 32'hD3C2_B1A0;
        req_valid = 4'hF;
        for (int f = 0; f < 8; f++) wait_end(60, "fair");
        req_valid = 4'h0;
        chk("fair_n_grants", grant_q.size(), 8);
        chk("fair_n_starts", txd_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_q.size()) chk($sformatf("fair_gnt%0d", i), grant_q[i], i % 4);
            if (i < txd_q.size()) chk($sformatf("fair_txd%0d", i), txd_q[i], 32'hA0 + (i % 4) * 32'h11);
        end
        chk("fair_n_gaps", gap_q.size(), 7);
        foreach (gap_q[i]) chk($sformatf("fair_gap%0d", i), gap_q[i], 1);
        chk("fair_done_cnt", done_cnt, 9);

        // Skip over idle requesters
        req_data = 32'h4433_2211;
        req_valid = 4'b0010;
        tick();
        chk("sk_r1", 32'(s_ready), 32'h2);
        req_valid = 4'b0000;
        wait_end(60, "sk1");
        req_valid = 4'b0011;
        tick();
        chk("sk_r0", 32'(s_ready), 32'h1);
        req_valid = 4'b0000;
        tick();
        chk("sk_txd0", 32'(s_txd), 32'h11);
        wait_end(60, "sk0");
        req_valid = 4'b1001;
        tick();
        chk("sk_r3", 32'(s_ready), 32'h8);
        req_valid = 4'b0000;
        tick();
        chk("sk_txd3", 32'(s_txd), 32'h44);
        chk("sk_gid3", 32'(s_gid), 32'h3);
        wait_end(60, "sk3");

        // Transmitter busy when the request arrives
        xmode = 2;
        tx_busy = 1'b1;
        req_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bz_hold%0d", i), 32'(s_ready), 32'h0);
        end
        tx_busy = 1'b0;
        xmode = 0;
        tick();
        chk("bz_grant", 32'(s_ready), 32'h4);
        req_valid = 4'b0000;
        wait_end(60, "bz");

        // Start timeout
        xmode = 1;
        tx_busy = 1'b0;
        req_data = 32'h0000_005A;
        req_valid = 4'b0001;
        tick();
        chk("to_ready", 32'(s_ready), 32'h1);
        req_valid = 4'b0000;
        tick();
        chk("to_start", 32'(s_start), 32'h1);
        dn = done_cnt;
        en = err_cnt;
        wait_end(40, "to");
        chk("to_err_cnt", err_cnt, en + 1);
        chk("to_no_done", done_cnt, dn);
        chk("to_lat", err_cyc - start_cyc, 16);
        tick();
        chk("to_idle", 32'(s_busy), 32'h0);
        chk("to_err_pulse", 32'(s_err), 32'h0);
        xmode = 0;

        // Reset during WAIT_DONE
        req_data = 32'h0077_0000;
        req_valid = 4'b0100;
        tick();
        chk("rs_ready", 32'(s_ready), 32'h4);
        req_valid = 4'b0000;
        repeat (6) tick();
        chk("rs_in_frame", 32'(s_busy), 32'h1);
        dn = done_cnt;
        en = err_cnt;
        req_valid = 4'b1010;
        #1 rst = 1'b0;
        #1;
        chk("rs_ready0", 32'(req_ready), 32'h0);
        chk("rs_start0", 32'(tx_start), 32'h0);
        chk("rs_txd0",   32'(tx_data), 32'h0);
        chk("rs_gid0",   32'(grant_id), 32'h3);
        chk("rs_busy0",  32'(busy), 32'h0);
        chk("rs_done0",  32'(done), 32'h0);
        chk("rs_err0",   32'(err), 32'h0);
        xmode = 2;
        dly = 0;
        rem = 0;
        tx_busy = 1'b0;
        #1 chk("rs_ready_gated", 32'(req_ready), 32'h0);
        rst = 1'b1;
        tick();
        chk("rs_first", 32'(s_ready), 32'h2);
        chk("rs_no_done", done_cnt, dn);
        chk("rs_no_err", err_cnt, en);
        req_valid = 4'b0000;
        xmode = 0;
        wait_end(60, "rs");

        chk("excl", excl_bad, 0);
        chk("onehot", onehot_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter BIT_MAX, default 8: byte width per requester and on tx_data.
REQ-002 Parameter WAIT_MAX, default 16: clock cycles allowed for tx_busy to rise after tx_start.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port req_valid, input, 4: requester i has a byte pending.
REQ-006 Port req_data, input, 4*BIT_MAX: byte of requester i at bits [i*BIT_MAX +: BIT_MAX].
REQ-007 Port req_ready, output, 4: one-hot, one-cycle accept pulse to the granted requester.
REQ-008 Port tx_data, output, BIT_MAX: byte presented to the shared UART transmitter.
REQ-009 Port tx_start, output, 1: one-cycle launch pulse to the transmitter.
REQ-010 Port tx_busy, input, 1: transmitter is shifting a frame.
REQ-011 Port grant_id, output, 2: index of the current or last granted requester.
REQ-012 Port busy, output, 1: high whenever state is not IDLE.
REQ-013 Port done, output, 1: one-cycle pulse when a granted frame completes.
REQ-014 Port err, output, 1: one-cycle pulse on transmitter start timeout.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE: when req_valid is nonzero and tx_busy=0, the FSM SHALL select a winner, latch its byte, pulse req_ready[winner] in that cycle and go to LAUNCH.
REQ-017 IDLE: when tx_busy=1, the FSM SHALL not grant and SHALL keep req_ready=0.
REQ-018 Arbitration SHALL be round-robin: search from last_grant+1 upward, modulo 4; the first requester with valid set wins.
REQ-019 last_grant and grant_id SHALL update to the winner in the accept cycle.
REQ-020 LAUNCH: tx_start SHALL be 1 for exactly this one cycle, with tx_data already equal to the latched byte; next state is WAIT_BUSY.
REQ-021 WAIT_BUSY: if tx_busy=1, go to WAIT_DONE; otherwise increment the wait counter.
REQ-022 WAIT_BUSY timeout: when the counter reaches WAIT_MAX-1 with tx_busy still 0, the FSM SHALL pulse err for one cycle and return to IDLE; the byte is dropped, not retried.
REQ-023 The wait counter SHALL clear on entry to WAIT_BUSY and SHALL be wide enough for WAIT_MAX-1 with no wrap.
REQ-024 WAIT_DONE: on tx_busy=0, the FSM SHALL pulse done for one cycle and return to IDLE.
REQ-025 Minimum spacing SHALL be one IDLE cycle between a done pulse and the next req_ready pulse.
REQ-026 tx_data SHALL hold the latched byte unchanged from LAUNCH until the next accept; req_data changes after acceptance SHALL have no effect.
REQ-027 Requesters hold valid and data until they see ready; valid dropping before grant withdraws the request with no side effect.
REQ-028 A requester whose valid stays high SHALL be served again only after every other asserted requester has been served once.
REQ-029 req_ready, tx_start, done and err SHALL never be asserted in the same cycle as each other.

Reset
REQ-030 When rst=0, the block SHALL go to IDLE immediately.
REQ-031 Reset values: req_ready=0, tx_start=0, tx_data=0, grant_id=3, last_grant=3, busy=0, done=0, err=0, wait counter=0.
REQ-032 Reset mid-frame SHALL abandon the byte with no done or err pulse; after release, requester 0 has first priority.

Verification
REQ-033 Single request: req_valid=4'b0001, req_data[7:0]=8'hA5, transmitter model asserts busy 2 cycles after tx_start for 20 cycles -> ready[0] pulse, tx_start next cycle with tx_data=A5, done once, grant_id=0.
REQ-034 Fairness: req_valid=4'b1111 held for 8 frames -> grant order 0,1,2,3,0,1,2,3, one req_ready pulse per frame.
REQ-035 Skip: after requester 1 is served, req_valid=4'b0011 -> requester 0 wins next; then req_valid=4'b1001 -> requester 3 wins.
REQ-036 Timeout: tx_busy tied 0 -> err pulses exactly WAIT_MAX cycles after tx_start, FSM returns to IDLE, no done pulse.
REQ-037 Transmitter busy at request: tx_busy=1 while req_valid=4'b0100 -> no req_ready until tx_busy falls; grant occurs on the first IDLE cycle with tx_busy=0.
REQ-038 Reset in WAIT_DONE: pulse rst=0 -> all outputs take reset values asynchronously; after release, the first grant goes to the lowest-index valid requester.
